// File: rtl/alu_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub_pipe
// Description : Two-stage pipelined adder/subtractor feeding the ALU compare
//               stage. Stage 1 adds the low half, stage 2 the high half and
//               derives Z/V/N. Valid/ready handshake on both sides.
//               Optional overflow-event counter enabled by the macro
//               ALU_ADDSUB_OVFCNT_EN (OvfCnt reads 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub_pipe #(
    parameter int WIDTH = 32            // must be even; split point is WIDTH/2
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active-low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic [15:0]      OvfCnt
);

    localparam int c_HALF = WIDTH / 2;

    // Flow control
    logic w_adv1;
    logic w_adv2;

    // Stage 1 state
    logic              r_s1_valid;
    logic [c_HALF-1:0] r_lo;
    logic              r_c_lo;
    logic [c_HALF-1:0] r_a_hi;
    logic [c_HALF-1:0] r_bx_hi;
    logic              r_sub;
    logic              r_sign;

    // Stage 2 state (drives the outputs directly)
    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_s;
    logic              r_z;
    logic              r_v;
    logic              r_n;

    // Combinational datapath
    logic [WIDTH-1:0]  w_bx;
    logic [c_HALF:0]   w_lo_sum;
    logic [c_HALF:0]   w_hi_sum;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;
    logic              w_ovf_signed;
    logic              w_z;
    logic              w_v;
    logic              w_n;

    // A stage may load when it is empty or its occupant leaves this cycle.
    // Ready only depends on downstream ready and local valids, never the reverse.
    assign w_adv2   = ~r_s2_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    // Subtraction is A + ~B + 1; the +1 enters as the low-half carry-in.
    assign w_bx     = Sub ? ~B : B;
    assign w_lo_sum = {1'b0, A[c_HALF-1:0]} + {1'b0, w_bx[c_HALF-1:0]}
                    + {{c_HALF{1'b0}}, Sub};

    // Stage 1: low-half add, carry out and high-half operands captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_lo       <= '0;
            r_c_lo     <= 1'b0;
            r_a_hi     <= '0;
            r_bx_hi    <= '0;
            r_sub      <= 1'b0;
            r_sign     <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_lo    <= w_lo_sum[c_HALF-1:0];
                r_c_lo  <= w_lo_sum[c_HALF];
                r_a_hi  <= A[WIDTH-1:c_HALF];
                r_bx_hi <= w_bx[WIDTH-1:c_HALF];
                r_sub   <= Sub;
                r_sign  <= Sign;
            end
        end
    end

    // High-half add completes the sum; the MSBs of A and Bx live in the high half.
    assign w_hi_sum     = {1'b0, r_a_hi} + {1'b0, r_bx_hi} + {{c_HALF{1'b0}}, r_c_lo};
    assign w_sum        = {w_hi_sum[c_HALF-1:0], r_lo};
    assign w_cout       = w_hi_sum[c_HALF];
    assign w_ovf_signed = (r_a_hi[c_HALF-1] == r_bx_hi[c_HALF-1])
                        & (w_sum[WIDTH-1] != r_a_hi[c_HALF-1]);

    // Flag selection: signed rules, unsigned add (carry) or unsigned sub (borrow)
    always_comb begin
        w_z = (w_sum == '0);
        w_v = 1'b0;
        w_n = 1'b0;
        if (r_sign) begin
            w_v = w_ovf_signed;
            w_n = w_sum[WIDTH-1];
        end else if (r_sub) begin
            w_v = 1'b0;
            w_n = ~w_cout;
        end else begin
            w_v = w_cout;
            w_n = 1'b0;
        end
    end

    // Stage 2: result and flag registers, held while downstream stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s        <= '0;
            r_z        <= 1'b0;
            r_v        <= 1'b0;
            r_n        <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s <= w_sum;
                r_z <= w_z;
                r_v <= w_v;
                r_n <= w_n;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign S         = r_s;
    assign Z         = r_z;
    assign V         = r_v;
    assign N         = r_n;

`ifdef ALU_ADDSUB_OVFCNT_EN
    logic        r_s2_sign;
    logic [15:0] r_ovfcnt;
    logic        w_consume;

    assign w_consume = r_s2_valid & out_ready;

    // Carry the signed-mode bit alongside the stage 2 result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_sign <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_s2_sign <= r_sign;
        end
    end

    // Count consumed signed-overflow results, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovfcnt <= 16'h0000;
        end else if (w_consume && r_s2_sign && r_v && (r_ovfcnt != 16'hFFFF)) begin
            r_ovfcnt <= r_ovfcnt + 16'd1;
        end
    end

    assign OvfCnt = r_ovfcnt;
`else
    assign OvfCnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_addsub_pipe
// Description : Self-checking bench for alu_addsub_pipe: directed vector
//               table, back-pressure and mid-flight reset sequences, random
//               traffic against a queue-based reference model, and counter
//               saturation when ALU_ADDSUB_OVFCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_addsub_pipe;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Sub;
    logic        Sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        Z;
    logic        V;
    logic        N;
    logic [15:0] OvfCnt;

    alu_addsub_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Sub       (Sub),
        .Sign      (Sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Z         (Z),
        .V         (V),
        .N         (N),
        .OvfCnt    (OvfCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sign;
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
        logic        sign;
        int          age;   // clock edges survived since acceptance
    } beat_t;

    vec_t        vec [9];
    beat_t       q [$];
    logic [31:0] got [$];
    logic [15:0] ovf_model;
    logic        last_acc;
    logic        seen_ready;
    int          n_checks;
    int          n_fail;
    int          idx;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corners [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic on the operands
    function automatic beat_t ref_calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic sign);
        beat_t  r;
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ur = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        r.s    = ur[31:0];
        r.z    = (r.s == 32'd0);
        r.sign = sign;
        r.age  = 0;
        if (sign) begin
            r.v = (sr > SMAX) || (sr < SMIN);
            r.n = r.s[31];
        end else if (!sub) begin
            r.v = (ur > UMAX);
            r.n = 1'b0;
        end else begin
            r.v = 1'b0;
            r.n = (ua < ub);
        end
        return r;
    endfunction

    // One clock cycle: apply inputs, check outputs against the model, advance the model
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sign, input logic ordy);
        logic vis, acc, cons;
        in_valid  = v;
        A         = a;
        B         = b;
        Sub       = sub;
        Sign      = sign;
        out_ready = ordy;
        #1;
        vis  = (q.size() > 0) && (q[0].age >= 1);
        acc  = v && ((q.size() < 2) || ordy);
        cons = vis && ordy;
        seen_ready = in_ready;
        chk("out_valid", {31'd0, out_valid}, {31'd0, vis});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || ordy});
        if (vis) begin
            chk("S", S, q[0].s);
            chk("Z", {31'd0, Z}, {31'd0, q[0].z});
            chk("V", {31'd0, V}, {31'd0, q[0].v});
            chk("N", {31'd0, N}, {31'd0, q[0].n});
        end
        chk("OvfCnt", {16'd0, OvfCnt}, {16'd0, ovf_model});
        if (cons) got.push_back(S);
        @(posedge clk);
        #1;
        foreach (q[i]) q[i].age++;
        if (cons) begin
`ifdef ALU_ADDSUB_OVFCNT_EN
            if (q[0].sign && q[0].v && (ovf_model != 16'hFFFF)) ovf_model++;
`endif
            void'(q.pop_front());
        end
        if (acc) q.push_back(ref_calc(a, b, sub, sign));
        last_acc = acc;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ovf_model = 16'h0000;
        last_acc  = 1'b0;
        //           a             b             sub   sign  s             z     v     n
        vec[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vec[1] = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
        vec[2] = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
        vec[3] = '{32'h0001FFFF, 32'h0001FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vec[4] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vec[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vec[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vec[7] = '{32'h00000005, 32'h00000003, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vec[8] = '{32'h00000000, 32'h80000000, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1};
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00010000};

        // Reset state
        reset = 1'b0; in_valid = 1'b0; A = '0; B = '0; Sub = 1'b0; Sign = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_S", S, 32'd0);
        chk("rst_ZVN", {29'd0, Z, V, N}, 32'd0);
        chk("rst_OvfCnt", {16'd0, OvfCnt}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors: two-cycle latency and table-derived results
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, vec[i].a, vec[i].b, vec[i].sub, vec[i].sign, 1'b1);
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_S", i), S, vec[i].s);
            chk($sformatf("vec%0d_ZVN", i), {29'd0, Z, V, N},
                {29'd0, vec[i].z, vec[i].v, vec[i].n});
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        end

        // Back-pressure: four beats offered while downstream is stalled
        got.delete();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 32'(idx + 1), 32'(idx + 1), 1'b0, 1'b0, 1'b0);
            if (c >= 2) chk($sformatf("bp_in_ready_c%0d", c), {31'd0, seen_ready}, 32'd0);
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            if (idx < 4) cycle(1'b1, 32'(idx + 1), 32'(idx + 1), 1'b0, 1'b0, 1'b1);
            else         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (last_acc) idx++;
        end
        chk("bp_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk($sformatf("bp_res%0d", k), got[k], 32'(2 * (k + 1)));
        end

        // Reset with two beats in flight
        cycle(1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd30, 32'd40, 1'b0, 1'b0, 1'b0);
        chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_S", S, 32'd0);
        chk("mid_rst_ZVN", {29'd0, Z, V, N}, 32'd0);
        chk("mid_rst_OvfCnt", {16'd0, OvfCnt}, 32'd0);
        q.delete();
        ovf_model = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
            cycle($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        for (int c = 0; c < 4; c++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

`ifdef ALU_ADDSUB_OVFCNT_EN
        // Counter saturation
        for (int c = 0; c < 65540; c++) cycle(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("ovf_saturated", {16'd0, OvfCnt}, 32'h0000FFFF);
`else
        chk("ovf_tied_zero", {16'd0, OvfCnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Two-stage pipelined 32-bit adder/subtractor.
- Produces the result S and the Z/V/N flags consumed directly downstream by the ALU comparison stage. That stage turns Z/V/N plus ALUFun into a 0/1 compare result.
- Replaces the single-cycle add path so the ALU datapath can close timing at the higher core clock.
- Valid/ready handshake on both sides; one result per cycle when not stalled.

Parameters:
- WIDTH, 32, operand/result width; must be even (split point WIDTH/2).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 1 can accept a beat.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0 = A+B, 1 = A-B (ALUFun[0] of the ALU).
- Sign  input  1  1 = signed flag rules, 0 = unsigned.
- out_valid  output  1  S/Z/V/N valid.
- out_ready  input  1  downstream accepts.
- S  output  WIDTH  result.
- Z  output  1  S == 0.
- V  output  1  overflow (see rules).
- N  output  1  negative / less-than (see rules).
- OvfCnt  output  16  overflow event count (optional feature).

Behaviour:
- Reset (reset=0, async): s1_valid=0, s2_valid=0, S=0, Z=0, V=0, N=0, OvfCnt=0. in_ready reads 1 once reset deasserts.
- Accept rules:
  - Input beat accepted when in_valid & in_ready.
  - Output beat consumed when out_valid & out_ready.
- Stage 1, on accept:
  - Bx = Sub ? ~B : B; cin = Sub.
  - Register lo = A[WIDTH/2-1:0] + Bx[lo] + cin, with carry c_lo.
  - Register A_hi, Bx_hi, Sub, Sign; set s1_valid.
- Stage 2, on advance:
  - {c_out, hi} = A_hi + Bx_hi + c_lo; S = {hi, lo}.
  - Register S and flags; set s2_valid.
- Flag rules:
  - Z = (S == 0) in all modes.
  - Signed: V = (A[msb]==Bx[msb]) & (S[msb]!=A[msb]); N = S[msb].
  - Unsigned add: V = c_out; N = 0.
  - Unsigned sub: V = 0; N = ~c_out (borrow, i.e. A<B).
- Flow control:
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1 (combinational from out_ready; no ready-to-valid loop since valid never depends on ready).
- Latency and throughput:
  - Accepted beat appears on outputs exactly 2 cycles later when unstalled.
  - Throughput 1 beat/cycle.
- Stall:
  - out_valid=1 & out_ready=0 holds S/Z/V/N/out_valid stable.
  - Stage 1 holds if full.
  - With both stages full, in_ready=0. Max 2 beats in flight; no data loss or reordering.
- Simultaneous accept and consume while full: both stages advance in the same cycle, throughput preserved.
- Stage 1 bubble while stage 2 drains: s2_valid clears if out_ready=1 and s1_valid=0.
- Reset mid-operation: in-flight beats are discarded, outputs return to reset values immediately; no partial beat is emitted after release.
- Wrap-around is plain modulo 2^WIDTH. Flags carry overflow information; S is never saturated.

Optional Feature:
- Macro: ALU_ADDSUB_OVFCNT_EN.
- Defined:
  - OvfCnt increments by 1 on each consumed output beat with Sign=1 and V=1.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: OvfCnt is tied to 0, counter logic absent. The port list is unchanged.

Test Plan:
- Signed add, unstalled: A=0x7FFFFFFF, B=1, Sub=0, Sign=1 -> after 2 cycles S=0x80000000, V=1, N=1, Z=0; OvfCnt=1 with macro, 0 without.
- Unsigned sub: A=3, B=5, Sub=1, Sign=0 -> S=0xFFFFFFFE, N=1, V=0, Z=0. Same operands with Sign=1 -> N=1, V=0.
- Equality and carry across the split: A=0x0001FFFF, B=0x0001FFFF, Sub=1 -> S=0, Z=1, N=0. A=0x0000FFFF, B=1, Sub=0 -> S=0x00010000, Z=0.
- Back-pressure: hold out_ready=0, drive 4 consecutive beats (1+1, 2+2, 3+3, 4+4).
  - Only 2 accepted; in_ready=0 from the third cycle.
  - Release out_ready -> results 2, 4, 6, 8 in order, one per cycle once flowing.
- Reset mid-flight: 2 beats in flight, pull reset low for 1 cycle -> out_valid=0, S=0 immediately; after release no stale beat appears and in_ready=1.
- Counter saturation (macro defined): force 65536 signed-overflow beats -> OvfCnt stays at 0xFFFF.
